execute_cc_stage: RTL and testbench

- Execute-stage back end of the Y86-64 pipeline; sits directly downstream of the 64-bit ALU/adder.
- Consumes the ALU result and overflow flag, maintains the condition-code register (ZF/SF/OF), and evaluates the branch/cmov condition.
- Owns the E->M pipeline register that feeds the memory stage, with stall and bubble control.

---
 rtl/execute_cc_stage.sv | 132 +++++++++++++
 tb/tb_execute_cc_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cc_stage.sv
// Y86-64 execute-stage back end: condition-code register, branch/cmov condition and E->M register.
// Optional build macro PERF_CNT_EN adds CC-update and taken-condition counters.
module execute_cc_stage #(
    parameter int         WIDTH = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    e_valid,
    input  logic [3:0]              e_icode,
    input  logic [3:0]              e_ifun,
    input  logic signed [WIDTH-1:0] alu_result,
    input  logic                    alu_overflow,
    input  logic [WIDTH-1:0]        e_valA,
    input  logic [3:0]              e_dstE,
    input  logic [3:0]              e_dstM,
    input  logic [1:0]              e_stat,
    input  logic                    m_exc,
    input  logic                    w_exc,
    input  logic                    m_stall,
    input  logic                    m_bubble,
    output logic                    cc_zf,
    output logic                    cc_sf,
    output logic                    cc_of,
    output logic                    e_cnd,
    output logic                    M_valid,
    output logic [3:0]              M_icode,
    output logic                    M_cnd,
    output logic [WIDTH-1:0]        M_valE,
    output logic [WIDTH-1:0]        M_valA,
    output logic [3:0]              M_dstE,
    output logic [3:0]              M_dstM,
    output logic [1:0]              M_stat
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]             cc_upd_cnt,
    output logic [31:0]             cnd_taken_cnt
`endif
);

    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [3:0] I_JXX  = 4'h7;

    function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                       input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (ifun)
            4'd0:    cond_eval = 1'b1;
            4'd1:    cond_eval = lt | zf;
            4'd2:    cond_eval = lt;
            4'd3:    cond_eval = zf;
            4'd4:    cond_eval = !zf;
            4'd5:    cond_eval = !lt;
            4'd6:    cond_eval = !lt & !zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    logic set_cc;
    logic m_capture;

    // CC writes are suppressed while an older instruction is faulting or M is frozen.
    assign set_cc    = e_valid & (e_icode == I_OPQ) & !m_exc & !w_exc & !m_stall;
    assign m_capture = !m_stall & !m_bubble & e_valid;
    assign e_cnd     = cond_eval(e_ifun, cc_zf, cc_sf, cc_of);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (set_cc) begin
            cc_zf <= (alu_result == '0);
            cc_sf <= alu_result[WIDTH-1];
            cc_of <= alu_overflow;
        end
    end

    // E->M boundary: stall outranks bubble; an empty E slot also becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_valid <= 1'b0;
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
            M_stat  <= 2'b00;
        end else if (!m_stall) begin
            if (m_capture) begin
                M_valid <= 1'b1;
                M_icode <= e_icode;
                M_cnd   <= e_cnd;
                M_valE  <= $unsigned(alu_result);
                M_valA  <= e_valA;
                M_dstE  <= ((e_icode == I_CMOV) && !e_cnd) ? RNONE : e_dstE;
                M_dstM  <= e_dstM;
                M_stat  <= e_stat;
            end else begin
                M_valid <= 1'b0;
                M_icode <= I_NOP;
                M_cnd   <= 1'b0;
                M_valE  <= '0;
                M_valA  <= '0;
                M_dstE  <= RNONE;
                M_dstM  <= RNONE;
                M_stat  <= 2'b00;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic taken_capture;

    assign taken_capture = m_capture & e_cnd & ((e_icode == I_CMOV) || (e_icode == I_JXX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_upd_cnt    <= '0;
            cnd_taken_cnt <= '0;
        end else begin
            if (set_cc) cc_upd_cnt <= cc_upd_cnt + 32'd1;
            if (taken_capture) cnd_taken_cnt <= cnd_taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_execute_cc_stage.sv
// Table-driven bench for execute_cc_stage with a queue of expected M-register/CC results.
module tb_execute_cc_stage;

    localparam logic [1:0] K_CAP  = 2'd0;
    localparam logic [1:0] K_HOLD = 2'd1;
    localparam logic [1:0] K_BUB  = 2'd2;
    localparam int NV = 24;

    typedef struct {
        logic        v;
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [63:0] res;
        logic        ov;
        logic [3:0]  de;
        logic        mx;
        logic        wx;
        logic        stl;
        logic        bub;
        logic        xcnd;
        logic [2:0]  xcc;
        logic [1:0]  xkind;
        logic [3:0]  xde;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [1:0]  stat;
        logic [2:0]  cc;
    } mexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        e_valid;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic signed [63:0] alu_result;
    logic        alu_overflow;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic [1:0]  e_stat;
    logic        m_exc;
    logic        w_exc;
    logic        m_stall;
    logic        m_bubble;
    logic        cc_zf, cc_sf, cc_of, e_cnd;
    logic        M_valid;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [1:0]  M_stat;
`ifdef PERF_CNT_EN
    logic [31:0] cc_upd_cnt;
    logic [31:0] cnd_taken_cnt;
`endif

    int total = 0;
    int bad = 0;
    vec_t  vecs[NV];
    mexp_t sb[$];
    mexp_t last_m;
    mexp_t bub_m;

    execute_cc_stage #(.WIDTH(64), .RNONE(4'hF)) dut (
        .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .e_valA(e_valA),
        .e_dstE(e_dstE), .e_dstM(e_dstM), .e_stat(e_stat), .m_exc(m_exc), .w_exc(w_exc),
        .m_stall(m_stall), .m_bubble(m_bubble), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .e_cnd(e_cnd), .M_valid(M_valid), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat)
`ifdef PERF_CNT_EN
        , .cc_upd_cnt(cc_upd_cnt), .cnd_taken_cnt(cnd_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] res, input logic ov, input logic [3:0] de,
                                input logic mx, input logic wx, input logic stl, input logic bub,
                                input logic xcnd, input logic [2:0] xcc, input logic [1:0] xkind,
                                input logic [3:0] xde);
        vec_t r;
        r.v = v; r.ic = ic; r.fn = fn; r.res = res; r.ov = ov; r.de = de;
        r.mx = mx; r.wx = wx; r.stl = stl; r.bub = bub;
        r.xcnd = xcnd; r.xcc = xcc; r.xkind = xkind; r.xde = xde;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_bubble_state(input string tag);
        chk({tag, " cc_zf"}, 64'(cc_zf), 64'd1);
        chk({tag, " cc_sf"}, 64'(cc_sf), 64'd0);
        chk({tag, " cc_of"}, 64'(cc_of), 64'd0);
        chk({tag, " M_valid"}, 64'(M_valid), 64'd0);
        chk({tag, " M_icode"}, 64'(M_icode), 64'd1);
        chk({tag, " M_cnd"}, 64'(M_cnd), 64'd0);
        chk({tag, " M_valE"}, M_valE, 64'd0);
        chk({tag, " M_dstE"}, 64'(M_dstE), 64'hF);
        chk({tag, " M_dstM"}, 64'(M_dstM), 64'hF);
    endtask

    task automatic idle_inputs();
        e_valid = 1'b0; e_icode = 4'h1; e_ifun = 4'h0; alu_result = '0; alu_overflow = 1'b0;
        e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF; e_stat = 2'b00;
        m_exc = 1'b0; w_exc = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    endtask

    initial begin
        // inputs: v ic fn res ov dstE mx wx stall bubble | expected: e_cnd cc{zf,sf,of} kind M_dstE
        vecs[0]  = mk(1'b1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, K_CAP, 4'h2);
        vecs[1]  = mk(1'b1, 4'h7, 4'h2, 64'h1234, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, K_CAP, 4'hF);
        vecs[2]  = mk(1'b1, 4'h7, 4'h1, 64'h1234, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, K_CAP, 4'hF);
        vecs[3]  = mk(1'b1, 4'h6, 4'h0, 64'h0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, K_CAP, 4'h5);
        vecs[4]  = mk(1'b1, 4'h2, 4'h3, 64'h77, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, K_CAP, 4'h3);
        vecs[5]  = mk(1'b1, 4'h2, 4'h4, 64'h77, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, K_CAP, 4'hF);
        vecs[6]  = mk(1'b1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, K_CAP, 4'h6);
        vecs[7]  = mk(1'b1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, K_CAP, 4'h6);
        vecs[8]  = mk(1'b1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, K_CAP, 4'h6);
        vecs[9]  = mk(1'b1, 4'h7, 4'h5, 64'h10, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, K_CAP, 4'hF);
        vecs[10] = mk(1'b1, 4'h7, 4'h2, 64'h20, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, K_CAP, 4'hF);
        vecs[11] = mk(1'b1, 4'h6, 4'h0, 64'h42, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, K_HOLD, 4'h7);
        vecs[12] = mk(1'b1, 4'h6, 4'h0, 64'h42, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, K_HOLD, 4'h7);
        vecs[13] = mk(1'b1, 4'h6, 4'h0, 64'h0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, K_BUB, 4'hF);
        vecs[14] = mk(1'b0, 4'h6, 4'h0, 64'h99, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, K_BUB, 4'hF);
        vecs[15] = mk(1'b1, 4'h7, 4'h1, 64'h30, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, K_CAP, 4'hF);
        vecs[16] = mk(1'b1, 4'h1, 4'h9, 64'h0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, K_CAP, 4'hF);
        vecs[17] = mk(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, K_CAP, 4'h8);
        vecs[18] = mk(1'b1, 4'h7, 4'h4, 64'h40, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, K_CAP, 4'hF);
        vecs[19] = mk(1'b1, 4'h7, 4'h6, 64'h40, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, K_CAP, 4'hF);
        vecs[20] = mk(1'b1, 4'h7, 4'h5, 64'h40, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, K_CAP, 4'hF);
        vecs[21] = mk(1'b1, 4'h7, 4'h3, 64'h40, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, K_CAP, 4'hF);
        vecs[22] = mk(1'b1, 4'h2, 4'h7, 64'h55, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, K_CAP, 4'hF);
        vecs[23] = mk(1'b1, 4'h2, 4'h0, 64'h55, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, K_CAP, 4'h9);

        bub_m = '{valid: 1'b0, icode: 4'h1, cnd: 1'b0, vale: 64'h0, vala: 64'h0,
                  dste: 4'hF, dstm: 4'hF, stat: 2'b00, cc: 3'b100};
        last_m = bub_m;

        idle_inputs();
        rst = 1'b1;
        #13;
        check_bubble_state("power-on reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            mexp_t e;
            @(negedge clk);
            e_valid = vecs[i].v; e_icode = vecs[i].ic; e_ifun = vecs[i].fn;
            alu_result = vecs[i].res; alu_overflow = vecs[i].ov;
            e_valA = 64'h1000 + 64'(i); e_dstE = vecs[i].de; e_dstM = 4'(i);
            e_stat = 2'(i); m_exc = vecs[i].mx; w_exc = vecs[i].wx;
            m_stall = vecs[i].stl; m_bubble = vecs[i].bub;
            #1;
            chk($sformatf("row%0d e_cnd", i), 64'(e_cnd), 64'(vecs[i].xcnd));
            case (vecs[i].xkind)
                K_CAP: e = '{valid: 1'b1, icode: vecs[i].ic, cnd: vecs[i].xcnd,
                             vale: vecs[i].res, vala: 64'h1000 + 64'(i), dste: vecs[i].xde,
                             dstm: 4'(i), stat: 2'(i), cc: vecs[i].xcc};
                K_HOLD: begin e = last_m; e.cc = vecs[i].xcc; end
                default: begin e = bub_m; e.cc = vecs[i].xcc; end
            endcase
            last_m = e;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("row%0d scoreboard empty", i), 64'd0, 64'd1);
            end else begin
                mexp_t x;
                x = sb.pop_front();
                chk($sformatf("row%0d cc", i), 64'({cc_zf, cc_sf, cc_of}), 64'(x.cc));
                chk($sformatf("row%0d M_valid", i), 64'(M_valid), 64'(x.valid));
                chk($sformatf("row%0d M_icode", i), 64'(M_icode), 64'(x.icode));
                chk($sformatf("row%0d M_cnd", i), 64'(M_cnd), 64'(x.cnd));
                chk($sformatf("row%0d M_valE", i), M_valE, x.vale);
                chk($sformatf("row%0d M_valA", i), M_valA, x.vala);
                chk($sformatf("row%0d M_dstE", i), 64'(M_dstE), 64'(x.dste));
                chk($sformatf("row%0d M_dstM", i), 64'(M_dstM), 64'(x.dstm));
                chk($sformatf("row%0d M_stat", i), 64'(M_stat), 64'(x.stat));
            end
        end

`ifdef PERF_CNT_EN
        chk("cc_upd_cnt", 64'(cc_upd_cnt), 64'd5);
        chk("cnd_taken_cnt", 64'(cnd_taken_cnt), 64'd7);
`endif

        // Mid-cycle asynchronous reset: state must clear with no clock edge.
        @(negedge clk);
        idle_inputs();
        m_stall = 1'b1;
        #2;
        chk("pre-reset M_valid", 64'(M_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_bubble_state("async reset");
`ifdef PERF_CNT_EN
        chk("reset cc_upd_cnt", 64'(cc_upd_cnt), 64'd0);
        chk("reset cnd_taken_cnt", 64'(cnd_taken_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        m_stall = 1'b0;

        // After reset a bubble cycle keeps the reset state.
        @(posedge clk);
        #1;
        check_bubble_state("post-reset idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
